// File: rtl/spi_slave_axis.sv
// SPI mode-0 slave bridged to AXI-Stream.
// All SPI pins are oversampled in the clk domain; MOSI bytes leave on m_axis_*,
// response bytes arrive on s_axis_* into a small TX FIFO and are shifted out on MISO.
//
// Frame tracker states:
//   state    | meaning
//   ST_WAIT  | after reset; waits for sync chain to fill and CS to be seen high
//   ST_IDLE  | CS high, ready to accept a new frame on the next CS falling edge
//   ST_FRAME | CS low, frame in progress; SCK edges are acted on
module spi_slave_axis #(
  parameter int          SYNC_STAGES = 2,
  parameter int          TX_DEPTH    = 4,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic       rx_overrun,
  output logic       frame_end
);

  localparam int PW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FRAME = 2'd2
  } frame_state_t;

  frame_state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES:0]   sync_fill;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_s;
  logic                   cs_s;
  logic                   mosi_s;

  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sck_rise;
  logic                   sck_fall;

  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic                   byte_done;
  logic                   rx_accept;

  logic [7:0]             tx_mem [TX_DEPTH];
  logic [PW:0]            wr_ptr;
  logic [PW:0]            rd_ptr;
  logic                   tx_empty;
  logic                   tx_full;
  logic                   tx_push;
  logic                   tx_load;
  logic                   tx_pop;
  logic [7:0]             tx_shift;

  logic                   unused_tlast;

  // TLAST carries no meaning for a byte-oriented SPI response stream.
  assign unused_tlast = s_axis_tlast;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Pin synchronizers plus one delay flop on SCK/CS for edge detection.
  // Reset values match the idle pin state so no edge is seen on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sync_fill <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sync_fill <= {sync_fill[SYNC_STAGES-1:0], 1'b1};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WAIT;
    else     state <= state_nxt;
  end

  // Frame tracking; a CS that is already low when reset releases never
  // reaches ST_IDLE first, so that frame is ignored.
  always_comb begin
    state_nxt = state;
    cs_fall   = 1'b0;
    cs_rise   = 1'b0;
    sck_rise  = 1'b0;
    sck_fall  = 1'b0;
    case (state)
      ST_WAIT: begin
        if (sync_fill[SYNC_STAGES] && cs_s && cs_d) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (cs_d && !cs_s) begin
          cs_fall   = 1'b1;
          state_nxt = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (!cs_d && cs_s) begin
          cs_rise   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!cs_s) begin
          sck_rise = sck_s && !sck_d;
          sck_fall = !sck_s && sck_d;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  assign spi_miso_oe = (state == ST_FRAME);

  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign rx_accept = byte_done && (!m_axis_tvalid || m_axis_tready);

  // Bit counter and MOSI shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
    end else if (cs_fall || cs_rise) begin
      bit_cnt <= 3'd0;
    end else if (sck_rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= {rx_shift[5:0], mosi_s};
    end
  end

  // Output byte register; a completing byte takes priority over the clear
  // so a handshake in the same cycle never causes an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= 8'd0;
      m_axis_tvalid <= 1'b0;
    end else if (rx_accept) begin
      m_axis_tdata  <= {rx_shift, mosi_s};
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Sticky overrun flag, cleared at the start of each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         rx_overrun <= 1'b0;
    else if (cs_fall)                rx_overrun <= 1'b0;
    else if (byte_done && !rx_accept) rx_overrun <= 1'b1;
  end

  // One-cycle pulse at the end of every frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_end <= 1'b0;
    else     frame_end <= cs_rise;
  end

  assign tx_empty      = (wr_ptr == rd_ptr);
  assign tx_full       = (wr_ptr[PW] != rd_ptr[PW]) &&
                         (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign s_axis_tready = !tx_full;
  assign tx_push       = s_axis_tvalid && !tx_full;
  assign tx_load       = cs_fall || (sck_fall && (bit_cnt == 3'd0));
  assign tx_pop        = tx_load && !tx_empty;

  // TX FIFO storage; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[wr_ptr[PW-1:0]] <= s_axis_tdata;
  end

  // TX FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // MISO shift register: reload at byte boundaries, shift on other falling edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= IDLE_BYTE;
    end else if (tx_load) begin
      tx_shift <= tx_empty ? IDLE_BYTE : tx_mem[rd_ptr[PW-1:0]];
    end else if (sck_fall) begin
      tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  assign spi_miso = tx_shift[7];

endmodule

// File: tb/tb_spi_slave_axis.sv
// Directed bench for spi_slave_axis: a bit-banged SPI host, an AXI-Stream
// scoreboard for received bytes and direct MISO byte checks.
module tb_spi_slave_axis;

  logic       clk;
  logic       rst;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic       rx_overrun;
  logic       frame_end;

  int         tests = 0;
  int         fails = 0;
  int         fe_cnt = 0;
  int         fe_base;
  logic [7:0] rx_exp [$];
  logic [7:0] got;
  logic [7:0] burst [16];

  spi_slave_axis #(
    .SYNC_STAGES(2),
    .TX_DEPTH   (4),
    .IDLE_BYTE  (8'hFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_sck      (spi_sck),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .rx_overrun   (rx_overrun),
    .frame_end    (frame_end)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Consumer side: every handshake pops the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_end) fe_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        check("rx_beat_expected", 32'(rx_exp.size() != 0), 32'd1);
        if (rx_exp.size() != 0) check("rx_data", 32'(m_axis_tdata), 32'(rx_exp.pop_front()));
      end
    end
  end

  task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] miso_byte);
    miso_byte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = d[7-i];
      tick(5);
      spi_sck = 1'b1;
      miso_byte = {miso_byte[6:0], spi_miso};
      tick(5);
      spi_sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] d, input logic [7:0] exp_miso, input logic exp_rx);
    logic [7:0] m;
    if (exp_rx) rx_exp.push_back(d);
    spi_bits(d, 8, m);
    check("miso_byte", 32'(m), 32'(exp_miso));
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(10);
  endtask

  task automatic cs_high();
    tick(5);
    spi_cs_n = 1'b1;
    tick(10);
  endtask

  task automatic push(input logic [7:0] d);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    tick(1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
    check({tag, "_miso"},   32'(spi_miso),      32'd1);
    check({tag, "_oe"},     32'(spi_miso_oe),   32'd0);
    check({tag, "_tready"}, 32'(s_axis_tready), 32'd1);
    check({tag, "_ovr"},    32'(rx_overrun),    32'd0);
    check({tag, "_fe"},     32'(frame_end),     32'd0);
  endtask

  initial begin
    burst = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00,
              8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rst           = 1'b1;
    spi_sck       = 1'b0;
    spi_cs_n      = 1'b1;
    spi_mosi      = 1'b0;
    m_axis_tready = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(10);

    // Basic RX with empty FIFO, then full-duplex response on the second byte.
    cs_low();
    check("oe_in_frame", 32'(spi_miso_oe), 32'd1);
    push(8'hA5);
    xfer(8'h01, 8'hFF, 1'b1);
    xfer(8'h00, 8'hA5, 1'b1);
    cs_high();
    check("oe_after_frame", 32'(spi_miso_oe), 32'd0);

    // Write-command burst in one frame.
    cs_low();
    for (int i = 0; i < 16; i++) xfer(burst[i], 8'hFF, 1'b1);
    cs_high();
    check("burst_no_overrun", 32'(rx_overrun), 32'd0);
    check("burst_drained", 32'(rx_exp.size()), 32'd0);

    // Overrun: consumer stalled, second byte dropped.
    m_axis_tready = 1'b0;
    cs_low();
    xfer(8'h11, 8'hFF, 1'b1);
    xfer(8'h22, 8'hFF, 1'b0);
    cs_high();
    check("ovr_tdata_held", 32'(m_axis_tdata), 32'h11);
    check("ovr_tvalid_held", 32'(m_axis_tvalid), 32'd1);
    check("ovr_sticky", 32'(rx_overrun), 32'd1);
    m_axis_tready = 1'b1;
    tick(3);
    check("ovr_single_beat", 32'(m_axis_tvalid), 32'd0);

    // Partial byte: next CS fall clears overrun, CS rise after 3 bits discards.
    cs_low();
    check("ovr_cleared_on_cs_fall", 32'(rx_overrun), 32'd0);
    fe_base = fe_cnt;
    spi_bits(8'hA0, 3, got);
    cs_high();
    check("partial_frame_end_once", 32'(fe_cnt - fe_base), 32'd1);
    check("partial_no_beat", 32'(m_axis_tvalid), 32'd0);
    cs_low();
    xfer(8'h5A, 8'hFF, 1'b1);
    cs_high();

    // FIFO ordering and full flag.
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    check("fifo_full_tready", 32'(s_axis_tready), 32'd0);
    cs_low();
    check("fifo_tready_after_pop", 32'(s_axis_tready), 32'd1);
    push(8'h14);
    xfer(8'h61, 8'h10, 1'b1);
    xfer(8'h62, 8'h11, 1'b1);
    xfer(8'h63, 8'h12, 1'b1);
    xfer(8'h64, 8'h13, 1'b1);
    xfer(8'h65, 8'h14, 1'b1);
    xfer(8'h66, 8'hFF, 1'b1);
    cs_high();

    // Asynchronous reset mid-byte.
    cs_low();
    spi_bits(8'hC3, 4, got);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick(2);
    rst = 1'b0;
    tick(10);
    // CS already low at release: frame ignored.
    spi_bits(8'h77, 8, got);
    tick(10);
    check("ignored_no_beat", 32'(m_axis_tvalid), 32'd0);
    check("ignored_oe_low", 32'(spi_miso_oe), 32'd0);
    fe_base = fe_cnt;
    cs_high();
    check("ignored_no_frame_end", 32'(fe_cnt - fe_base), 32'd0);
    cs_low();
    xfer(8'h3C, 8'hFF, 1'b1);
    cs_high();

    for (int i = 0; i < 200 && rx_exp.size() != 0; i++) tick(1);
    check("rx_queue_drained", 32'(rx_exp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
